// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants, state encoding and hold-count helper for the fetch unit
//
// Purpose: widths, instruction class encodings, class field position, FSM
//          state encoding and the per-class hold-count function. The control
//          unit imports the same class constants.
// Ports:   none (package).
package instr_fetch_pkg;

  localparam int INSTR_WIDTH  = 20;
  localparam int ADDR_BITS    = 5;
  localparam int STD_CYCLES   = 3;
  localparam int LOAD_CYCLES  = 4;
  localparam int STORE_CYCLES = 3;

  // Wide enough for the longest hold plus the extra first-instruction cycle.
  localparam int CNT_BITS = 3;

  // Class field position inside an instruction word.
  localparam int CLS_HI = 19;
  localparam int CLS_LO = 18;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  // Number of cycles the control unit spends on an instruction of this class.
  function automatic logic [CNT_BITS-1:0] hold_cycles(input logic [1:0] cls);
    case (cls)
      CLS_STD:   return CNT_BITS'(STD_CYCLES);
      CLS_LOAD:  return CNT_BITS'(LOAD_CYCLES);
      CLS_STORE: return CNT_BITS'(STORE_CYCLES);
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - program-write and instruction-presentation bus of the fetch unit
//
// Purpose: groups the run request, the instruction memory write port and the
//          instruction outputs toward the control unit.
// Signals: run, prog_we, prog_addr, prog_data (into the fetch unit);
//          instr, pc, instr_valid, halted (out of the fetch unit);
//          pc_load, pc_load_addr only when IFU_PC_LOAD_EN is defined.
// Modports: slave = fetch unit side, master = driver/observer side.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic                   run;
  logic                   prog_we;
  logic [ADDR_BITS-1:0]   prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_BITS-1:0]   pc;
  logic                   instr_valid;
  logic                   halted;
`ifdef IFU_PC_LOAD_EN
  logic                   pc_load;
  logic [ADDR_BITS-1:0]   pc_load_addr;

  modport slave (
    input  run, prog_we, prog_addr, prog_data, pc_load, pc_load_addr,
    output instr, pc, instr_valid, halted
  );
  modport master (
    output run, prog_we, prog_addr, prog_data, pc_load, pc_load_addr,
    input  instr, pc, instr_valid, halted
  );
`else
  modport slave (
    input  run, prog_we, prog_addr, prog_data,
    output instr, pc, instr_valid, halted
  );
  modport master (
    output run, prog_we, prog_addr, prog_data,
    input  instr, pc, instr_valid, halted
  );
`endif

endinterface

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - 2^ADDR_BITS x INSTR_WIDTH instruction store
//
// Purpose: synchronous write, combinational read. Contents are never reset.
// Ports:   clk; we_i, waddr_i, wdata_i (write port); raddr_i -> rdata_o (read).
module instr_mem
  import instr_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [ADDR_BITS-1:0]   waddr_i,
  input  logic [INSTR_WIDTH-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0]   raddr_i,
  output logic [INSTR_WIDTH-1:0] rdata_o
);

  logic [INSTR_WIDTH-1:0] mem_q [2**ADDR_BITS];

  // A write and a fetch of the same address on one edge see the old word,
  // since the fetch samples rdata_o before this update lands.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit feeding the control unit
//
// Purpose: program counter plus hold counter; presents each instruction for
//          the number of cycles its class needs, halts on class-00 words or
//          after the last address. Optional macro IFU_PC_LOAD_EN adds a
//          pending PC redirect taken at the next instruction boundary.
// Ports:   clk, rst (sync, active-high); ifu_bus (instr_fetch_if.slave):
//          run, prog_we/prog_addr/prog_data in; instr, pc, instr_valid,
//          halted out; pc_load/pc_load_addr in with IFU_PC_LOAD_EN.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  ifu_bus
);

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;

  logic [ADDR_BITS-1:0]   next_pc;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [INSTR_WIDTH-1:0] rd_word;
  logic [1:0]             rd_cls;
  logic                   redirect;
  logic [ADDR_BITS-1:0]   redirect_addr;

`ifdef IFU_PC_LOAD_EN
  logic                   pend_q, pend_d;
  logic [ADDR_BITS-1:0]   pend_addr_q, pend_addr_d;

  // A pulse on the boundary cycle itself wins over an older pending load.
  assign redirect      = ifu_bus.pc_load | pend_q;
  assign redirect_addr = ifu_bus.pc_load ? ifu_bus.pc_load_addr : pend_addr_q;
`else
  assign redirect      = 1'b0;
  assign redirect_addr = '0;
`endif

  assign next_pc = redirect ? redirect_addr : pc_q + 1'b1;
  // IDLE always fetches address 0; RUN pre-reads the word for the next boundary.
  assign rd_addr = (state_q == ST_RUN) ? next_pc : '0;
  assign rd_cls  = rd_word[CLS_HI:CLS_LO];

  instr_mem u_mem (
    .clk     (clk),
    .we_i    (ifu_bus.prog_we),
    .waddr_i (ifu_bus.prog_addr),
    .wdata_i (ifu_bus.prog_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef IFU_PC_LOAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
`ifdef IFU_PC_LOAD_EN
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        instr_d  = '0;
        valid_d  = 1'b0;
        halted_d = 1'b0;
        cnt_d    = '0;
        if (ifu_bus.run) begin
          pc_d = '0;
          if (rd_cls == CLS_HALT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            instr_d = rd_word;
            valid_d = 1'b1;
            // Extra cycle covers the control unit's reset-to-decode step.
            cnt_d   = hold_cycles(rd_cls) + CNT_BITS'(1);
          end
        end
      end

      ST_RUN: begin
        if (cnt_q > CNT_BITS'(1)) begin
          cnt_d = cnt_q - CNT_BITS'(1);
`ifdef IFU_PC_LOAD_EN
          if (ifu_bus.pc_load) begin
            pend_d      = 1'b1;
            pend_addr_d = ifu_bus.pc_load_addr;
          end
`endif
        end else begin
          // Last hold cycle: the next word is loaded on this edge, no bubble.
`ifdef IFU_PC_LOAD_EN
          pend_d = 1'b0;
`endif
          if (!redirect && (pc_q == '1)) begin
            state_d  = ST_HALT;
            instr_d  = '0;
            valid_d  = 1'b0;
            halted_d = 1'b1;
            cnt_d    = '0;
          end else begin
            pc_d = next_pc;
            if (rd_cls == CLS_HALT) begin
              state_d  = ST_HALT;
              instr_d  = '0;
              valid_d  = 1'b0;
              halted_d = 1'b1;
              cnt_d    = '0;
            end else begin
              instr_d = rd_word;
              cnt_d   = hold_cycles(rd_cls);
            end
          end
        end
      end

      ST_HALT: begin
        instr_d  = '0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
        cnt_d    = '0;
      end

      default: begin
        state_d  = ST_IDLE;
        instr_d  = '0;
        pc_d     = '0;
        valid_d  = 1'b0;
        halted_d = 1'b0;
        cnt_d    = '0;
      end
    endcase

`ifdef IFU_PC_LOAD_EN
    if (state_q != ST_RUN) begin
      pend_d = 1'b0;
    end
`endif
  end

  assign ifu_bus.instr       = instr_q;
  assign ifu_bus.pc          = pc_q;
  assign ifu_bus.instr_valid = valid_q;
  assign ifu_bus.halted      = halted_q;

endmodule
